// File: rtl/calc_n_core.sv
// Multi-port two-operand calculator: per-port capture FSM and request queue,
// round-robin issue of one queued entry per cycle into registered responses.

module calc_n_port #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 2,
  parameter int DEPTH  = 4
) (
  input  logic              c_clk,
  input  logic              reset,
  input  logic [3:0]        cmd_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic [TAG_W-1:0]  tag_in,
  input  logic              pop_in,
  output logic              hd_vld_o,
  output logic [3:0]        hd_cmd_o,
  output logic [DATA_W-1:0] hd_op1_o,
  output logic [DATA_W-1:0] hd_op2_o,
  output logic [TAG_W-1:0]  hd_tag_o,
  output logic              full_o,
  output logic              drop_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 4 + 2*DATA_W + TAG_W;

  typedef enum logic {IDLE, OP2} state_t;

  state_t                     state_q, state_d;
  logic [3:0]                 cmd_q, cmd_d;
  logic [DATA_W-1:0]          op1_q, op1_d;
  logic [TAG_W-1:0]           tag_q, tag_d;
  logic [DEPTH-1:0][EW-1:0]   mem_q, mem_d;
  logic [AW-1:0]              wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic                       drop_q, drop_d;
  logic                       push, accept;

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    op1_d   = op1_q;
    tag_d   = tag_q;
    mem_d   = mem_q;
    wp_d    = wp_q;
    rp_d    = rp_q;
    drop_d  = drop_q;
    push    = 1'b0;
    case (state_q)
      IDLE: if (cmd_in != 4'd0) begin
        state_d = OP2;
        cmd_d   = cmd_in;
        op1_d   = data_in;
        tag_d   = tag_in;
      end
      OP2: begin
        state_d = IDLE;
        push    = 1'b1;
      end
    endcase
    // A full queue still takes the push when its head leaves on the same edge.
    accept = push && ((cnt_q != CW'(DEPTH)) || pop_in);
    if (accept) begin
      mem_d[wp_q] = {cmd_q, op1_q, data_in, tag_q};
      wp_d        = wp_q + 1'b1;
    end
    if (pop_in) rp_d = rp_q + 1'b1;
    if (push && !accept) drop_d = 1'b1;
    cnt_d = cnt_q + CW'(accept) - CW'(pop_in);
  end

  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      op1_q   <= '0;
      tag_q   <= '0;
      mem_q   <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      op1_q   <= op1_d;
      tag_q   <= tag_d;
      mem_q   <= mem_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
    end
  end

  assign {hd_cmd_o, hd_op1_o, hd_op2_o, hd_tag_o} = mem_q[rp_q];
  assign hd_vld_o = (cnt_q != '0);
  assign full_o   = (cnt_q == CW'(DEPTH));
  assign drop_o   = drop_q;
endmodule

module calc_n_core #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 32,
  parameter int TAG_W     = 2,
  parameter int DEPTH     = 4
) (
  input  logic                        c_clk,
  input  logic                        reset,
  input  logic [NUM_PORTS*4-1:0]      req_cmd_in,
  input  logic [NUM_PORTS*DATA_W-1:0] req_data_in,
  input  logic [NUM_PORTS*TAG_W-1:0]  req_tag_in,
  output logic [NUM_PORTS*2-1:0]      out_resp,
  output logic [NUM_PORTS*DATA_W-1:0] out_data,
  output logic [NUM_PORTS*TAG_W-1:0]  out_tag,
  output logic [NUM_PORTS-1:0]        out_full,
  output logic [NUM_PORTS-1:0]        drop_flag
);
  localparam int PW = $clog2(NUM_PORTS);
  localparam int SW = $clog2(DATA_W);

  logic [NUM_PORTS-1:0]             hd_vld, pop;
  logic [NUM_PORTS-1:0][3:0]        hd_cmd;
  logic [NUM_PORTS-1:0][DATA_W-1:0] hd_op1, hd_op2;
  logic [NUM_PORTS-1:0][TAG_W-1:0]  hd_tag;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    calc_n_port #(.DATA_W(DATA_W), .TAG_W(TAG_W), .DEPTH(DEPTH)) u_port (
      .c_clk    (c_clk),
      .reset    (reset),
      .cmd_in   (req_cmd_in[4*p +: 4]),
      .data_in  (req_data_in[DATA_W*p +: DATA_W]),
      .tag_in   (req_tag_in[TAG_W*p +: TAG_W]),
      .pop_in   (pop[p]),
      .hd_vld_o (hd_vld[p]),
      .hd_cmd_o (hd_cmd[p]),
      .hd_op1_o (hd_op1[p]),
      .hd_op2_o (hd_op2[p]),
      .hd_tag_o (hd_tag[p]),
      .full_o   (out_full[p]),
      .drop_o   (drop_flag[p])
    );
  end

  logic [PW-1:0] ptr_q, ptr_d, gnt_idx, cand;
  logic          gnt_vld;

  // Search starts at the port after the last grant.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = PW'((int'(ptr_q) + i) % NUM_PORTS);
      if (!gnt_vld && hd_vld[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
    pop   = '0;
    ptr_d = ptr_q;
    if (gnt_vld) begin
      pop[gnt_idx] = 1'b1;
      ptr_d = (int'(gnt_idx) == NUM_PORTS-1) ? '0 : gnt_idx + 1'b1;
    end
  end

  logic [3:0]        a_cmd;
  logic [DATA_W-1:0] a_op1, a_op2, res_data;
  logic [DATA_W:0]   sum;
  logic [1:0]        res_resp;

  always_comb begin
    a_cmd    = hd_cmd[gnt_idx];
    a_op1    = hd_op1[gnt_idx];
    a_op2    = hd_op2[gnt_idx];
    sum      = {1'b0, a_op1} + {1'b0, a_op2};
    res_resp = 2'd2;
    res_data = '0;
    case (a_cmd)
      4'd1: if (!sum[DATA_W]) begin
        res_resp = 2'd1;
        res_data = sum[DATA_W-1:0];
      end
      4'd2: if (a_op2 <= a_op1) begin
        res_resp = 2'd1;
        res_data = a_op1 - a_op2;
      end
      4'd3: begin
        res_resp    = 2'd1;
        res_data[0] = (a_op1 < a_op2);
      end
      4'd5: begin
        res_resp = 2'd1;
        res_data = a_op1 << a_op2[SW-1:0];
      end
      4'd6: begin
        res_resp = 2'd1;
        res_data = a_op1 >> a_op2[SW-1:0];
      end
      default: ;
    endcase
  end

  logic [NUM_PORTS-1:0][1:0]        resp_q, resp_d;
  logic [NUM_PORTS-1:0][DATA_W-1:0] data_q, data_d;
  logic [NUM_PORTS-1:0][TAG_W-1:0]  tag_q, tag_d;

  always_comb begin
    resp_d = '0;
    data_d = '0;
    tag_d  = '0;
    if (gnt_vld) begin
      resp_d[gnt_idx] = res_resp;
      data_d[gnt_idx] = res_data;
      tag_d[gnt_idx]  = hd_tag[gnt_idx];
    end
  end

  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      ptr_q  <= '0;
      resp_q <= '0;
      data_q <= '0;
      tag_q  <= '0;
    end else begin
      ptr_q  <= ptr_d;
      resp_q <= resp_d;
      data_q <= data_d;
      tag_q  <= tag_d;
    end
  end

  assign out_resp = resp_q;
  assign out_data = data_q;
  assign out_tag  = tag_q;
endmodule
